keypad_event_scheduler: RTL and testbench

- Converts the 12-bit debounced held-key vector of the 3x4 button plant into a serialized stream of press/release events.
- The 12 keys are requesters. A round-robin arbiter grants one event per cycle into a small FIFO, and the FIFO drains over a valid/ready handshake.
- Placed between button_plant_3x4_manager (o_key_save) and the UI/code-entry logic.

---
 rtl/keypad_pkg.sv | 37 +++
 rtl/keypad_event_fifo.sv | 72 +++++++
 rtl/keypad_event_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_keypad_event_scheduler.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants and event layout for the keypad event scheduler.
// Key index is row*3+col; an event word is {is_repeat, is_release, code[3:0]}.
package keypad_pkg;

    localparam int NUM_KEYS   = 12;
    localparam int KEY_CODE_W = 4;
    localparam int EVENT_W    = 6;

    typedef struct packed {
        logic                  is_repeat;
        logic                  is_release;
        logic [KEY_CODE_W-1:0] code;
    } key_event_t;

    localparam logic [KEY_CODE_W-1:0] KEY_0  = 4'd0;   // row 0, col 0
    localparam logic [KEY_CODE_W-1:0] KEY_1  = 4'd1;
    localparam logic [KEY_CODE_W-1:0] KEY_2  = 4'd2;
    localparam logic [KEY_CODE_W-1:0] KEY_3  = 4'd3;   // row 1, col 0
    localparam logic [KEY_CODE_W-1:0] KEY_4  = 4'd4;
    localparam logic [KEY_CODE_W-1:0] KEY_5  = 4'd5;
    localparam logic [KEY_CODE_W-1:0] KEY_6  = 4'd6;   // row 2, col 0
    localparam logic [KEY_CODE_W-1:0] KEY_7  = 4'd7;
    localparam logic [KEY_CODE_W-1:0] KEY_8  = 4'd8;
    localparam logic [KEY_CODE_W-1:0] KEY_9  = 4'd9;   // row 3, col 0
    localparam logic [KEY_CODE_W-1:0] KEY_10 = 4'd10;
    localparam logic [KEY_CODE_W-1:0] KEY_11 = 4'd11;

    function automatic key_event_t make_event(input logic [KEY_CODE_W-1:0] code,
                                              input logic rel, input logic rpt);
        key_event_t ev;
        ev.is_repeat  = rpt;
        ev.is_release = rel;
        ev.code       = code;
        return ev;
    endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// First-word-fall-through FIFO with registered full/empty flags.
// Pushes while full and pops while empty are ignored.
module keypad_event_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push & ~full_r;
    assign do_pop_s  = pop & ~empty_r;
    assign rd_data   = mem_r[rd_ptr_r];
    assign full      = full_r;
    assign empty     = empty_r;

    // Next occupancy from the accepted push/pop pair
    always_comb begin
        count_nxt_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_nxt_s = count_r + (AW+1)'(1'b1);
            2'b01:   count_nxt_s = count_r - (AW+1)'(1'b1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == FULL_CNT);
            empty_r <= (count_nxt_s == '0);
        end
    end

    // Storage; cleared so the head reads zero after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

endmodule

// File: rtl/keypad_event_scheduler.sv
// Turns held-key levels into a press/release event stream via round-robin arbitration and a FIFO.
// Optional auto-repeat of the last pressed key is enabled with `define KEYPAD_EVENT_AUTOREPEAT_EN.
module keypad_event_scheduler
    import keypad_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
`ifdef KEYPAD_EVENT_AUTOREPEAT_EN
    ,
    parameter logic [23:0] REPEAT_DELAY  = 24'd5_000_000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd1_000_000
`endif
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [NUM_KEYS-1:0]   i_key_save,
    output logic                  o_event_valid,
    input  logic                  i_event_ready,
    output logic [KEY_CODE_W-1:0] o_event_code,
    output logic                  o_event_release,
    output logic                  o_event_repeat,
    output logic                  o_overflow,
    input  logic                  i_overflow_clr
);

    logic [NUM_KEYS-1:0]   key_prev_r;
    logic [NUM_KEYS-1:0]   pend_press_r;
    logic [NUM_KEYS-1:0]   pend_rel_r;
    logic [KEY_CODE_W-1:0] rr_ptr_r;
    logic                  overflow_r;

    logic [NUM_KEYS-1:0]   rise_s, fall_s, req_s;
    logic [NUM_KEYS-1:0]   clr_press_s, clr_rel_s;
    logic [4:0]            idx_s;
    logic                  grant_valid_s, grant_s;
    logic [KEY_CODE_W-1:0] grant_idx_s;
    key_event_t            grant_evt_s, rep_evt_s, push_evt_s, head_s;
    logic                  rep_push_s, push_s;
    logic                  fifo_full_s, fifo_empty_s;
    logic                  ovf_evt_s;

    assign rise_s    = i_key_save & ~key_prev_r;
    assign fall_s    = ~i_key_save & key_prev_r;
    assign req_s     = pend_press_r | pend_rel_r;
    // A new edge on an already-pending flag of the same type collapses into it: one event is lost
    assign ovf_evt_s = |((rise_s & pend_press_r) | (fall_s & pend_rel_r));

    // Round-robin search for the first requester at or after the pointer
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = KEY_0;
        idx_s         = 5'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            idx_s = {1'b0, rr_ptr_r} + 5'(i);
            if (idx_s >= 5'd12) begin
                idx_s = idx_s - 5'd12;
            end else begin
                idx_s = idx_s;
            end
            if (!grant_valid_s && req_s[idx_s[3:0]]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = idx_s[3:0];
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end

    // Grant qualification, flag clears and the granted event (press before release)
    always_comb begin
        clr_press_s = 12'h000;
        clr_rel_s   = 12'h000;
        grant_s     = grant_valid_s & ~fifo_full_s;
        grant_evt_s = make_event(grant_idx_s, ~pend_press_r[grant_idx_s], 1'b0);
        if (grant_s) begin
            if (pend_press_r[grant_idx_s]) begin
                clr_press_s[grant_idx_s] = 1'b1;
            end else begin
                clr_rel_s[grant_idx_s] = 1'b1;
            end
        end else begin
            clr_press_s = 12'h000;
        end
    end

    // FIFO write source: key events first, repeat only when no key requests
    always_comb begin
        push_s = grant_s | rep_push_s;
        if (grant_s) begin
            push_evt_s = grant_evt_s;
        end else begin
            push_evt_s = rep_evt_s;
        end
    end

    // Edge history, pending flags, arbitration pointer and sticky overflow
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            key_prev_r   <= 12'h000;
            pend_press_r <= 12'h000;
            pend_rel_r   <= 12'h000;
            rr_ptr_r     <= KEY_0;
            overflow_r   <= 1'b0;
        end else begin
            key_prev_r   <= i_key_save;
            pend_press_r <= (pend_press_r & ~clr_press_s) | rise_s;
            pend_rel_r   <= (pend_rel_r & ~clr_rel_s) | fall_s;
            if (grant_s) begin
                rr_ptr_r <= (grant_idx_s == KEY_11) ? KEY_0 : grant_idx_s + 4'd1;
            end
            if (ovf_evt_s) begin
                overflow_r <= 1'b1;
            end else if (i_overflow_clr) begin
                overflow_r <= 1'b0;
            end
        end
    end

`ifdef KEYPAD_EVENT_AUTOREPEAT_EN
    logic [KEY_CODE_W-1:0] rep_key_r, rise_low_s;
    logic [23:0]           rep_cnt_r, rep_limit_s;
    logic                  rep_active_r, rep_first_r, rep_req_r, rep_drop_s;

    assign rep_push_s  = rep_req_r & ~grant_valid_s & ~fifo_full_s;
    assign rep_drop_s  = rep_req_r & fifo_full_s;
    assign rep_evt_s   = make_event(rep_key_r, 1'b0, 1'b1);
    assign rep_limit_s = rep_first_r ? (REPEAT_DELAY - 24'd1) : (REPEAT_PERIOD - 24'd1);

    // Lowest rising index (descending scan so the lowest overwrites last)
    always_comb begin
        rise_low_s = KEY_0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (rise_s[i]) begin
                rise_low_s = 4'(i);
            end else begin
                rise_low_s = rise_low_s;
            end
        end
    end

    // Hold timer for the most recently pressed key
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rep_key_r    <= KEY_0;
            rep_cnt_r    <= 24'd0;
            rep_active_r <= 1'b0;
            rep_first_r  <= 1'b1;
            rep_req_r    <= 1'b0;
        end else if (|rise_s) begin
            rep_key_r    <= rise_low_s;
            rep_cnt_r    <= 24'd0;
            rep_active_r <= 1'b1;
            rep_first_r  <= 1'b1;
            rep_req_r    <= 1'b0;
        end else if (rep_active_r && fall_s[rep_key_r]) begin
            rep_cnt_r    <= 24'd0;
            rep_active_r <= 1'b0;
            rep_req_r    <= 1'b0;
        end else begin
            if (rep_push_s || rep_drop_s) rep_req_r <= 1'b0;
            if (rep_active_r) begin
                if (rep_cnt_r == rep_limit_s) begin
                    rep_req_r   <= 1'b1;
                    rep_cnt_r   <= 24'd0;
                    rep_first_r <= 1'b0;
                end else begin
                    rep_cnt_r <= rep_cnt_r + 24'd1;
                end
            end
        end
    end
`else
    assign rep_push_s = 1'b0;
    assign rep_evt_s  = make_event(KEY_0, 1'b0, 1'b0);
`endif

    keypad_event_fifo #(
        .WIDTH (EVENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (aclk),
        .rst_n   (aresetn),
        .push    (push_s),
        .wr_data (push_evt_s),
        .pop     (i_event_ready),
        .rd_data (head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign o_event_valid   = ~fifo_empty_s;
    assign o_event_code    = head_s.code;
    assign o_event_release = head_s.is_release;
    assign o_event_repeat  = head_s.is_repeat;
    assign o_overflow      = overflow_r;

endmodule

// File: tb/tb_keypad_event_scheduler.sv
// Directed self-checking bench for keypad_event_scheduler (default build, auto-repeat disabled).
module tb_keypad_event_scheduler;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [11:0] i_key_save;
    logic        o_event_valid;
    logic        i_event_ready;
    logic [3:0]  o_event_code;
    logic        o_event_release;
    logic        o_event_repeat;
    logic        o_overflow;
    logic        i_overflow_clr;

    int tests_run = 0;
    int tests_failed = 0;

    keypad_event_scheduler dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .i_key_save      (i_key_save),
        .o_event_valid   (o_event_valid),
        .i_event_ready   (i_event_ready),
        .o_event_code    (o_event_code),
        .o_event_release (o_event_release),
        .o_event_repeat  (o_event_repeat),
        .o_overflow      (o_overflow),
        .i_overflow_clr  (i_overflow_clr)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Waits (bounded) for a head event, checks it, and lets it pop on the next edge
    task automatic expect_event(input string tag, input logic [3:0] code, input logic rel,
                                input int max_wait);
        int w = 0;
        while (!o_event_valid && w < max_wait) begin
            tick();
            w++;
        end
        check_eq({tag, " valid"}, 32'(o_event_valid), 32'd1);
        if (o_event_valid) begin
            check_eq({tag, " code"}, 32'(o_event_code), 32'(code));
            check_eq({tag, " release"}, 32'(o_event_release), 32'(rel));
            check_eq({tag, " repeat"}, 32'(o_event_repeat), 32'd0);
        end
        tick();
    endtask

    task automatic do_reset(input logic [11:0] keys);
        aresetn    = 1'b0;
        i_key_save = keys;
        repeat (2) tick();
        aresetn = 1'b1;
    endtask

    initial begin
        aresetn        = 1'b0;
        i_key_save     = 12'h000;
        i_event_ready  = 1'b0;
        i_overflow_clr = 1'b0;
        repeat (3) tick();
        check_eq("reset valid", 32'(o_event_valid), 32'd0);
        check_eq("reset overflow", 32'(o_overflow), 32'd0);
        check_eq("reset code", 32'(o_event_code), 32'd0);
        check_eq("reset release", 32'(o_event_release), 32'd0);
        check_eq("reset repeat", 32'(o_event_repeat), 32'd0);
        aresetn = 1'b1;
        tick();

        // Single press/release and two-cycle latency
        i_event_ready = 1'b1;
        i_key_save    = 12'h010;
        tick();
        check_eq("lat press N+1 valid", 32'(o_event_valid), 32'd0);
        tick();
        check_eq("lat press N+2 valid", 32'(o_event_valid), 32'd1);
        check_eq("lat press code", 32'(o_event_code), 32'd4);
        check_eq("lat press release", 32'(o_event_release), 32'd0);
        tick();
        check_eq("press popped", 32'(o_event_valid), 32'd0);
        i_key_save = 12'h000;
        tick();
        check_eq("lat rel N+1 valid", 32'(o_event_valid), 32'd0);
        tick();
        check_eq("lat rel N+2 valid", 32'(o_event_valid), 32'd1);
        check_eq("lat rel code", 32'(o_event_code), 32'd4);
        check_eq("lat rel release", 32'(o_event_release), 32'd1);
        tick();

        // Simultaneous rise from pointer 0, then releases confirm pointer back at 0
        do_reset(12'h000);
        i_event_ready = 1'b1;
        i_key_save    = 12'h881;
        tick();
        expect_event("sim p0", 4'd0, 1'b0, 2);
        expect_event("sim p7", 4'd7, 1'b0, 0);
        expect_event("sim p11", 4'd11, 1'b0, 0);
        check_eq("sim drained", 32'(o_event_valid), 32'd0);
        i_key_save = 12'h000;
        expect_event("sim r0", 4'd0, 1'b1, 3);
        expect_event("sim r7", 4'd7, 1'b1, 0);
        expect_event("sim r11", 4'd11, 1'b1, 0);

        // Backpressure: ten presses, FIFO holds eight, all delivered in order
        do_reset(12'h000);
        i_event_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            i_key_save[i] = 1'b1;
            tick();
        end
        repeat (12) tick();
        check_eq("bp valid held", 32'(o_event_valid), 32'd1);
        check_eq("bp head code", 32'(o_event_code), 32'd0);
        i_event_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            expect_event("bp press", 4'(i), 1'b0, 3);
        end
        check_eq("bp overflow", 32'(o_overflow), 32'd0);

        // Pending-flag overflow on key 2 behind a full FIFO
        i_event_ready = 1'b0;
        i_key_save    = 12'h000;
        repeat (12) tick();
        i_key_save = 12'h004;
        tick();
        i_key_save = 12'h000;
        tick();
        check_eq("ovf not yet", 32'(o_overflow), 32'd0);
        i_key_save = 12'h004;
        tick();
        tick();
        check_eq("ovf set", 32'(o_overflow), 32'd1);
        i_event_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            expect_event("ovf rel", 4'(i), 1'b1, 3);
        end
        expect_event("ovf key2 press", 4'd2, 1'b0, 3);
        expect_event("ovf key2 rel", 4'd2, 1'b1, 3);
        check_eq("ovf sticky", 32'(o_overflow), 32'd1);
        i_overflow_clr = 1'b1;
        tick();
        i_overflow_clr = 1'b0;
        check_eq("ovf cleared", 32'(o_overflow), 32'd0);

        // Reset mid-stream; held keys re-emit presses afterwards
        i_event_ready = 1'b0;
        i_key_save    = 12'h3E4;
        repeat (8) tick();
        check_eq("mid queued valid", 32'(o_event_valid), 32'd1);
        check_eq("mid queued head", 32'(o_event_code), 32'd5);
        aresetn = 1'b0;
        #1;
        check_eq("mid async valid", 32'(o_event_valid), 32'd0);
        tick();
        aresetn       = 1'b1;
        i_event_ready = 1'b1;
        expect_event("mid re p2", 4'd2, 1'b0, 3);
        expect_event("mid re p5", 4'd5, 1'b0, 0);
        expect_event("mid re p6", 4'd6, 1'b0, 0);
        expect_event("mid re p7", 4'd7, 1'b0, 0);
        expect_event("mid re p8", 4'd8, 1'b0, 0);
        expect_event("mid re p9", 4'd9, 1'b0, 0);

        // Keys released during reset leave no events
        aresetn    = 1'b0;
        i_key_save = 12'h000;
        tick();
        aresetn = 1'b1;
        repeat (5) tick();
        check_eq("rel in reset silent", 32'(o_event_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
